// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared encodings for the sequential ALU (groups, MDU ops, FSM)
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam logic [1:0] GRP_MDU   = 2'b00;
    localparam logic [1:0] GRP_ARITH = 2'b01;
    localparam logic [1:0] GRP_BOOL  = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    localparam logic [1:0] MDU_MUL   = 2'b00;
    localparam logic [1:0] MDU_MULHU = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_REMU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// seq_alu_if : operand/result handshake bundle of the sequential ALU
// Rev 1.0
// ============================================================================
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [5:0]      fn;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, src1, src2, fn, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, src1, src2, fn, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : bit-serial unsigned multiply (shift-add) / divide (restoring)
// Rev 1.0
// ============================================================================
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] value
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [1:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic              r_run;

    logic              w_is_div;
    logic              w_take_hi;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rpart;
    logic [XLEN-1:0]   w_trial;
    logic              w_ge;
    logic [2*XLEN-1:0] w_acc_nxt;

    assign w_is_div  = (r_op == MDU_DIVU) || (r_op == MDU_REMU);
    assign w_take_hi = (r_op == MDU_MULHU) || (r_op == MDU_REMU);

    // Multiply: {partial product, multiplier} shifts right, adding the
    // multiplicand into the high half whenever the outgoing bit is set.
    assign w_addend = r_acc[0] ? r_opnd : '0;
    assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};

    // Divide: {remainder, quotient} shifts left; a divisor of zero always
    // "fits", which yields all-ones quotient and remainder == dividend.
    assign w_rpart  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge     = (w_rpart >= {1'b0, r_opnd});
    assign w_trial  = w_rpart[XLEN-1:0] - r_opnd;

    always_comb begin
        w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};
        if (w_is_div) begin
            w_acc_nxt = w_ge ? {w_trial, r_acc[XLEN-2:0], 1'b1}
                             : {w_rpart[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    assign done  = r_run && (r_cnt == '0);
    assign value = w_take_hi ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_op   <= MDU_MUL;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (start) begin
            r_acc  <= {{XLEN{1'b0}}, src1};
            r_opnd <= src2;
            r_op   <= op;
            r_cnt  <= CW'(XLEN - 1);
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// seq_alu : handshaked integer execution unit with iterative unsigned MDU
// Rev 1.0
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    alu_state_t      r_state;
    alu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_mdu_value;
    logic [SHW-1:0]  w_shamt;
    logic [3:0]      w_tt;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_is_mdu;
    logic            w_mdu_done;
    logic            w_out_valid;
    logic            w_busy;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mdu   = (bus.fn[5:4] == GRP_MDU);
    assign w_shamt    = bus.src2[SHW-1:0];
    assign w_tt       = bus.fn[3:0];

    always_comb begin
        w_alu = '0;
        case (bus.fn[5:4])
            GRP_ARITH: w_alu = bus.fn[0] ? (bus.src1 - bus.src2) : (bus.src1 + bus.src2);
            GRP_BOOL: begin
                for (int i = 0; i < XLEN; i++) begin
                    w_alu[i] = w_tt[{bus.src1[i], bus.src2[i]}];
                end
            end
            GRP_SHIFT: begin
                case (bus.fn[1:0])
                    2'b01:   w_alu = bus.src1 >> w_shamt;
                    2'b11:   w_alu = $signed(bus.src1) >>> w_shamt;
                    default: w_alu = bus.src1 << w_shamt;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && w_is_mdu),
        .op    (bus.fn[1:0]),
        .src1  (bus.src1),
        .src2  (bus.src2),
        .done  (w_mdu_done),
        .value (w_mdu_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mdu ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                w_busy = 1'b1;
                if (w_mdu_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_is_mdu ? ST_BUSY : ST_DONE;
                end else if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Only ever written on accept or on the final MDU iteration, so the
    // value held in DONE stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_accept && !w_is_mdu) begin
            r_result <= w_alu;
        end else if ((r_state == ST_BUSY) && w_mdu_done) begin
            r_result <= w_mdu_value;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// tb_seq_alu : directed scoreboard bench for seq_alu (XLEN=32 and XLEN=8)
// Rev 1.0
// ============================================================================
module tb_seq_alu;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    seq_alu_if #(.XLEN(32)) bus ();
    seq_alu_if #(.XLEN(8))  bus8 ();

    seq_alu #(.XLEN(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    seq_alu #(.XLEN(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every completed output handshake pops one entry.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output observed=0x%08h expected=none", bus.result);
            end else begin
                chk("result", bus.result, exp_q.pop_front());
            end
        end
    end

    // Called and returns just after a rising edge; returns after the accept edge.
    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input bit push, output int waited);
        int budget;
        budget = 0;
        waited = 0;
        bus.fn = f;
        bus.src1 = a;
        bus.src2 = b;
        bus.in_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        while (!bus.in_ready && budget < 200) begin
            waited++;
            budget++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk1("accept_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic mdu_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
        int n, nb, w;
        drive(f, a, b, expv, 1'b1, w);
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid && bus.busy) nb++;
        end while (!bus.out_valid && n < 100);
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_cycles"}, nb, 32);
        chk1({tag, "_busy_at_done"}, bus.busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic mdu8(input string tag, input logic [5:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] expv);
        int n, nb;
        bus8.fn = f;
        bus8.src1 = a;
        bus8.src2 = b;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        chk1({tag, "_in_ready"}, bus8.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus8.out_valid && bus8.busy) nb++;
        end while (!bus8.out_valid && n < 50);
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_busy_cycles"}, nb, 8);
        chk({tag, "_value"}, 32'(bus8.result), 32'(expv));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.fn = '0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0;
        bus8.fn = '0;
        bus8.src1 = '0;
        bus8.src2 = '0;
        bus8.out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst8_out_valid", bus8.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arith/bool back-to-back: in_ready must never stall the producer
        drive(6'b010000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, w);
        chk("b2b_add_wait", w, 0);
        drive(6'b010001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, w);
        chk("b2b_sub_wait", w, 0);
        drive(6'b100110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b1, w);
        chk("b2b_xor_wait", w, 0);
        @(negedge clk);
        chk1("b2b_last_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        drain("b2b");

        // Shift and more bool truth tables
        drive(6'b110011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b1, w);
        drive(6'b110001, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b1, w);
        drive(6'b110000, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b1, w);
        drive(6'b110010, 32'h0000_0001, 32'h25, 32'h0000_0020, 1'b1, w);
        drive(6'b110001, 32'h8000_0000, 32'h25, 32'h0400_0000, 1'b1, w);
        drive(6'b101000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b1, w);
        drive(6'b101110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b1, w);
        drain("shift");

        // MDU values, latency and busy duration
        mdu_op("mul",      6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        mdu_op("mulhu",    6'b000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        mdu_op("divu",     6'b000010, 32'd100, 32'd7, 32'd14);
        mdu_op("remu",     6'b000011, 32'd100, 32'd7, 32'd2);
        mdu_op("divu_ign", 6'b001110, 32'd1000, 32'd10, 32'd100);
        mdu_op("divu_z",   6'b000010, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        mdu_op("remu_z",   6'b000011, 32'h1234, 32'h0, 32'h0000_1234);
        drain("mdu");

        // Backpressure: result held, inputs refused, then same-cycle accept
        bus.out_ready = 1'b0;
        drive(6'b010000, 32'd10, 32'd20, 32'd30, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_valid", bus.out_valid, 1'b1);
            chk("bp_result", bus.result, 32'd30);
            chk1("bp_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(6'b010001, 32'd50, 32'd8, 32'd42, 1'b1, w);
        chk("bp_accept_wait", w, 0);
        drain("bp");

        // Reset in the middle of an iterating multiply; its result must never appear
        drive(6'b000000, 32'd3, 32'd5, 32'd15, 1'b0, w);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk1("mid_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_out_valid", bus.out_valid, 1'b0);
        chk1("abort_busy", bus.busy, 1'b0);
        chk("abort_result", bus.result, 32'h0);
        chk1("abort_in_ready", bus.in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk1("abort_hold_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(6'b010000, 32'd2, 32'd2, 32'd4, 1'b1, w);
        drain("post_rst");

        // XLEN=8 instance
        mdu8("mul8",    6'b000000, 8'hFF, 8'hFF, 8'h01);
        mdu8("mulhu8",  6'b000001, 8'hFF, 8'hFF, 8'hFE);
        mdu8("divu8",   6'b000010, 8'd200, 8'd9, 8'd22);
        mdu8("remu8",   6'b000011, 8'd200, 8'd9, 8'd2);
        mdu8("divu8_z", 6'b000010, 8'h5A, 8'h00, 8'hFF);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the 32-bit combinational ALU in the NPC execute stage. It keeps the same 6-bit function encoding for the arith, bool and shift groups. It adds an iterative unsigned multiply/divide group in the previously unused `fn[5:4]=00` slot, and registers all results behind a valid/ready output. The block sits between the EXU operand latch and the writeback mux, and is the single execution unit for integer ops.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived, not overridden).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and `fn` valid.
- `in_ready` out 1: block can accept this cycle.
- `src1` in XLEN: operand A.
- `src2` in XLEN: operand B; the shift group uses `src2[SHW-1:0]`.
- `fn` in 6: `fn[5:4]` is the group, `fn[3:0]` the sub-op.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: registered result.
- `busy` out 1: high in BUSY (iterating mul/div), for perf counters.

## Operation
Groups (`fn[5:4]`):
- **00 MDU.** `fn[1:0]`:
  - 00: MUL, low XLEN bits of the product.
  - 01: MULHU, high XLEN bits of the unsigned product.
  - 10: DIVU.
  - 11: REMU.
  - `fn[3:2]` is ignored.
- **01 arith.** `fn[0]=0` gives src1+src2; `fn[0]=1` gives src1−src2. Both are mod 2^XLEN; no flags are produced.
- **10 bool.** Truth-table form: `result[i] = fn[{src1[i],src2[i]}]`. For example, 1000 is AND, 1110 is OR, 0110 is XOR.
- **11 shift.** `fn[1:0]`:
  - 00: SLL.
  - 01: SRL.
  - 11: SRA.
  - 10: SLL.

MDU semantics:
- All MDU ops are unsigned, computed as one bit per cycle using shift-add (mul) or restoring division (div).
- Divide by zero: DIVU returns all-ones and REMU returns src1. The op still takes the full iteration count.

FSM states IDLE, BUSY, DONE:
- **IDLE.** `in_ready=1`. On `in_valid`:
  - Non-MDU group: compute combinationally, latch into `result`, go to DONE.
  - MDU group: latch the operands, load `cnt=XLEN-1`, go to BUSY.
- **BUSY.** `in_ready=0`. One iteration per cycle, and `cnt` decrements. When `cnt==0`, write the final value to `result` and go to DONE.
- **DONE.** `out_valid=1`, and `result` is held stable until the handshake.
  - `in_ready = out_ready`.
  - If `out_ready` and not `in_valid`: go to IDLE.
  - If `out_ready` and `in_valid`: accept the new op in the same cycle, as from IDLE (back-to-back).
  - If not `out_ready`: stay; inputs are not accepted.
- **Reset.** Async assertion at any time, including mid-BUSY, immediately aborts the op:
  - state = IDLE, `out_valid=0`, `result=0`, `busy=0`, `cnt=0`.
  - No partial result is ever presented.

## Timing
- Non-MDU op accepted at edge t: `out_valid=1` with the correct `result` after edge t+1.
- MDU op accepted at edge t: BUSY for XLEN cycles, `out_valid=1` after edge t+XLEN+1.
- Sustained throughput:
  - Non-MDU: 1 op/cycle while `out_ready=1`.
  - MDU: 1 op per XLEN+1 cycles.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `out_valid` and `result` come straight from flops, with no combinational path from inputs.
- `busy` goes high the cycle after MDU accept and low the same cycle `out_valid` rises.

## Structure
- Package `alu_pkg` holds:
  - group constants `GRP_MDU`, `GRP_ARITH`, `GRP_BOOL`, `GRP_SHIFT`;
  - MDU sub-op constants `MDU_MUL`, `MDU_MULHU`, `MDU_DIVU`, `MDU_REMU`;
  - state enum `alu_state_t`.
- Sub-module `mdu_iter`, parametrised by XLEN:
  - inputs: start, op, operands; outputs: done, value;
  - owns the 2·XLEN accumulator/remainder register and the `cnt` counter.
- The combinational arith/bool/shift datapath stays inline in `seq_alu`.

## Test plan
- **Arith/bool back-to-back.** XLEN=32, `out_ready=1`:
  - cycle 0: ADD 0xFFFFFFFF+1;
  - cycle 1: SUB 3−5;
  - cycle 2: bool 0110 on 0xF0F0, 0xFF00.
  - Required: results 0x0, 0xFFFFFFFE, 0x0FF0 on consecutive cycles 1–3, with `in_ready` never low.
- **Shift.** SRA 0x80000000 by 31 gives 0xFFFFFFFF; SRL gives 0x1; SLL 1 by 31 gives 0x80000000. Only `src2[4:0]` is used (`src2=0x25` shifts by 5).
- **MDU latency and values.**
  - MUL 0xFFFFFFFF·0xFFFFFFFF gives 0x1; MULHU gives 0xFFFFFFFE; DIVU 100/7 gives 14; REMU gives 2.
  - Each has `out_valid` exactly 33 cycles after accept, and `busy` high for 32 cycles.
- **Divide by zero.** DIVU 0x1234/0 gives 0xFFFFFFFF; REMU gives 0x1234, after the full 33-cycle latency.
- **Backpressure.**
  - Hold `out_ready=0` for 5 cycles in DONE: `result` is stable and `in_ready=0`.
  - Raise `out_ready` together with `in_valid`: the new op is accepted that cycle.
- **Reset and parametrisation.**
  - Assert `rst_n=0` at BUSY cycle 10, release, then issue ADD 2+2: `out_valid` stays 0 through reset, and the first output is 0x4.
  - Repeat the MUL case with XLEN=8: latency is 9 cycles.
